// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: register read with WB bypass, load-use hazard detection,
// control decode and the ID/EX pipeline register with stall, flush and sticky halt.
module decode_stage #(
  parameter logic [5:0]  HALT_OP = 6'h3F,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             ifid_valid,
  input  logic [31:0]      ifid_instr,
  input  logic [31:0]      ifid_pc,
  output logic             ifid_stall,
  output logic [4:0]       rsel1,
  output logic [4:0]       rsel2,
  input  logic [31:0]      rdat1,
  input  logic [31:0]      rdat2,
  input  logic             wb_wen,
  input  logic [4:0]       wb_wsel,
  input  logic [31:0]      wb_wdat,
  input  logic             ex_ready,
  input  logic             flush,
  output logic             idex_valid,
  output logic [31:0]      idex_pc,
  output logic [31:0]      idex_rsdat,
  output logic [31:0]      idex_rtdat,
  output logic [31:0]      idex_imm,
  output logic [5:0]       idex_opcode,
  output logic [5:0]       idex_funct,
  output logic [4:0]       idex_shamt,
  output logic [4:0]       idex_dest,
  output logic             idex_memread,
  output logic             idex_memwrite,
  output logic             idex_regwrite,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rsdat;
    logic [31:0] rtdat;
    logic [31:0] imm;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        memread;
    logic        memwrite;
    logic        regwrite;
  } idex_t;

  state_e           state_q;
  idex_t            idex_q;
  idex_t            dec;
  logic [CNT_W-1:0] stall_count_q;
  logic             uses_rs;
  logic             uses_rt;
  logic             hazard;
  logic [5:0]       op;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;

  assign op    = ifid_instr[31:26];
  assign rs    = ifid_instr[25:21];
  assign rt    = ifid_instr[20:16];
  assign rd    = ifid_instr[15:11];
  assign rsel1 = rs;
  assign rsel2 = rt;

  // Register 0 never bypasses and always reads as zero.
  function automatic logic [31:0] bypass(input logic [4:0] sel, input logic [31:0] rdat,
                                         input logic wen, input logic [4:0] wsel,
                                         input logic [31:0] wdat);
    if (sel == 5'd0) return 32'h0;
    if (wen && wsel == sel) return wdat;
    return rdat;
  endfunction

  always_comb begin
    dec        = '0;
    uses_rs    = 1'b0;
    uses_rt    = 1'b0;
    dec.valid  = ifid_valid;
    dec.pc     = ifid_pc;
    dec.opcode = op;
    dec.funct  = ifid_instr[5:0];
    dec.shamt  = ifid_instr[10:6];
    dec.rsdat  = bypass(rs, rdat1, wb_wen, wb_wsel, wb_wdat);
    dec.rtdat  = bypass(rt, rdat2, wb_wen, wb_wsel, wb_wdat);
    dec.imm    = (op inside {6'h0C, 6'h0D, 6'h0E}) ? {16'h0, ifid_instr[15:0]}
                                                   : {{16{ifid_instr[15]}}, ifid_instr[15:0]};
    case (op)
      6'h00: begin
        dec.dest     = rd;
        dec.regwrite = (ifid_instr[5:0] != 6'h08);
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
      end
      6'h23: begin
        dec.dest     = rt;
        dec.memread  = 1'b1;
        dec.regwrite = 1'b1;
        uses_rs      = 1'b1;
      end
      6'h2B: begin
        dec.memwrite = 1'b1;
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
      end
      6'h04, 6'h05: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dec.dest     = rt;
        dec.regwrite = 1'b1;
        uses_rs      = (op != 6'h0F);
      end
      6'h03: begin
        dec.dest     = 5'd31;
        dec.regwrite = 1'b1;
      end
      default: ;
    endcase
    if (!dec.regwrite) dec.dest = 5'd0;
    if (dec.dest == 5'd0) dec.regwrite = 1'b0;
  end

  assign hazard = idex_q.valid && idex_q.memread && (idex_q.dest != 5'd0) && ifid_valid &&
                  ((uses_rs && rs == idex_q.dest) || (uses_rt && rt == idex_q.dest));

  assign ifid_stall = (state_q == StHalted) || !ex_ready || (!flush && hazard);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q       <= StRun;
      idex_q        <= '0;
      stall_count_q <= '0;
    end else if (ex_ready) begin
      unique case (state_q)
        StRun: begin
          if (flush) begin
            idex_q.valid <= 1'b0;
          end else if (hazard) begin
            idex_q.valid <= 1'b0;
            if (stall_count_q != '1) begin
              stall_count_q <= stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            idex_q <= dec;
            if (ifid_valid && op == HALT_OP) state_q <= StHalted;
          end
        end
        StHalted: begin
          idex_q.valid <= 1'b0;
          // A flush means the halt was fetched down a mispredicted path.
          if (flush) state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign idex_valid    = idex_q.valid;
  assign idex_pc       = idex_q.pc;
  assign idex_rsdat    = idex_q.rsdat;
  assign idex_rtdat    = idex_q.rtdat;
  assign idex_imm      = idex_q.imm;
  assign idex_opcode   = idex_q.opcode;
  assign idex_funct    = idex_q.funct;
  assign idex_shamt    = idex_q.shamt;
  assign idex_dest     = idex_q.dest;
  assign idex_memread  = idex_q.memread;
  assign idex_memwrite = idex_q.memwrite;
  assign idex_regwrite = idex_q.regwrite;
  assign halted        = (state_q == StHalted);
  assign stall_count   = stall_count_q;

endmodule
